// File: rtl/cu_multicycle_if.sv
// Handshake and control bundle between the fetch stage, data memory and the
// multi-cycle control unit.
interface cu_multicycle_if #(
  parameter int OPCODE_W = 7,
  parameter int ALU_W    = 3,
  parameter int CNT_W    = 16
);
  logic                instr_valid;
  logic                instr_ready;
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic [ALU_W-1:0]    alu_ctl;
  logic                alu_src_imm;
  logic                data_rom_read_en;
  logic                data_rom_write_en;
  logic                reg_write_en;
  logic                wb_sel_mem;
  logic                pc_en;
  logic                illegal_op;
  logic                busy;
  logic [CNT_W-1:0]    retired;

  modport master (
    output instr_valid, opcode, mem_ready,
    input  instr_ready, alu_ctl, alu_src_imm, data_rom_read_en,
           data_rom_write_en, reg_write_en, wb_sel_mem, pc_en,
           illegal_op, busy, retired
  );

  modport slave (
    input  instr_valid, opcode, mem_ready,
    output instr_ready, alu_ctl, alu_src_imm, data_rom_read_en,
           data_rom_write_en, reg_write_en, wb_sel_mem, pc_en,
           illegal_op, busy, retired
  );
endinterface

// File: rtl/cu_multicycle.sv
// Multi-cycle control unit: steps each accepted opcode through
// FETCH/DECODE/EXEC/MEM/WB and counts retired legal instructions.
module cu_multicycle #(
  parameter int                  OPCODE_W = 7,
  parameter int                  ALU_W    = 3,
  parameter logic [OPCODE_W-1:0] OP_ADD   = 7'b0110011,
  parameter logic [OPCODE_W-1:0] OP_ADDI  = 7'b0010011,
  parameter logic [OPCODE_W-1:0] OP_LW    = 7'b0000011,
  parameter logic [OPCODE_W-1:0] OP_SW    = 7'b0100011,
  parameter logic [ALU_W-1:0]    ALU_ADD  = 3'b000,
  parameter logic [ALU_W-1:0]    ALU_NOP  = 3'b111,
  parameter int                  CNT_W    = 16
) (
  input logic              clk,
  input logic              rst_n,
  cu_multicycle_if.slave   bus
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              state;
  state_t              state_nxt;
  logic [OPCODE_W-1:0] op_q;
  logic [CNT_W-1:0]    retired_q;

  logic                is_add;
  logic                is_addi;
  logic                is_lw;
  logic                is_sw;
  logic                is_legal;
  logic                retire;

  logic                instr_ready;
  logic [ALU_W-1:0]    alu_ctl;
  logic                alu_src_imm;
  logic                rd_en;
  logic                wr_en;
  logic                reg_write_en;
  logic                wb_sel_mem;
  logic                pc_en;
  logic                illegal_op;

  assign is_add   = (op_q == OP_ADD);
  assign is_addi  = (op_q == OP_ADDI);
  assign is_lw    = (op_q == OP_LW);
  assign is_sw    = (op_q == OP_SW);
  assign is_legal = is_add | is_addi | is_lw | is_sw;

  // The opcode is captured only on the accepting edge, so later bus changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && bus.instr_valid) begin
        op_q <= bus.opcode;
      end
      if (retire) begin
        retired_q <= retired_q + CNT_ONE;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    instr_ready  = 1'b0;
    alu_ctl      = ALU_NOP;
    alu_src_imm  = 1'b0;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    reg_write_en = 1'b0;
    wb_sel_mem   = 1'b0;
    pc_en        = 1'b0;
    illegal_op   = 1'b0;
    retire       = 1'b0;
    case (state)
      S_FETCH: begin
        instr_ready = 1'b1;
        if (bus.instr_valid) begin
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_nxt = S_EXEC;
        end else begin
          illegal_op = 1'b1;
          pc_en      = 1'b1;
          state_nxt  = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_ctl     = ALU_ADD;
        alu_src_imm = !is_add;
        state_nxt   = (is_lw || is_sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        // A store retires straight out of MEM in the cycle memory completes.
        alu_ctl     = ALU_ADD;
        alu_src_imm = 1'b1;
        rd_en       = is_lw;
        wr_en       = is_sw;
        if (bus.mem_ready) begin
          if (is_lw) begin
            state_nxt = S_WB;
          end else begin
            pc_en     = 1'b1;
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end
        end
      end
      S_WB: begin
        alu_ctl      = ALU_ADD;
        alu_src_imm  = !is_add;
        reg_write_en = 1'b1;
        wb_sel_mem   = is_lw;
        pc_en        = 1'b1;
        retire       = 1'b1;
        state_nxt    = S_FETCH;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  assign bus.instr_ready       = instr_ready;
  assign bus.alu_ctl           = alu_ctl;
  assign bus.alu_src_imm       = alu_src_imm;
  assign bus.data_rom_read_en  = rd_en;
  assign bus.data_rom_write_en = wr_en;
  assign bus.reg_write_en      = reg_write_en;
  assign bus.wb_sel_mem        = wb_sel_mem;
  assign bus.pc_en             = pc_en;
  assign bus.illegal_op        = illegal_op;
  assign bus.busy              = (state != S_FETCH);
  assign bus.retired           = retired_q;

endmodule

// File: tb/tb_cu_multicycle.sv
// Bench for cu_multicycle: two instances (16-bit and 2-bit retire counters)
// share one stimulus stream and are checked cycle by cycle against a model.
module tb_cu_multicycle;

  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_NOP = 3'b111;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic [6:0] opcode;
  logic       mem_ready;

  int          compareCount;
  int          failCount;
  int unsigned retiredCount;

  cu_multicycle_if #(.OPCODE_W(7), .ALU_W(3), .CNT_W(16)) bus16 ();
  cu_multicycle_if #(.OPCODE_W(7), .ALU_W(3), .CNT_W(2))  bus2 ();

  assign bus16.instr_valid = instr_valid;
  assign bus16.opcode      = opcode;
  assign bus16.mem_ready   = mem_ready;
  assign bus2.instr_valid  = instr_valid;
  assign bus2.opcode       = opcode;
  assign bus2.mem_ready    = mem_ready;

  cu_multicycle #(.CNT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  cu_multicycle #(.CNT_W(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] vec16;
  logic [11:0] vec2;
  assign vec16 = {bus16.instr_ready, bus16.alu_ctl, bus16.alu_src_imm,
                  bus16.data_rom_read_en, bus16.data_rom_write_en,
                  bus16.reg_write_en, bus16.wb_sel_mem, bus16.pc_en,
                  bus16.illegal_op, bus16.busy};
  assign vec2  = {bus2.instr_ready, bus2.alu_ctl, bus2.alu_src_imm,
                  bus2.data_rom_read_en, bus2.data_rom_write_en,
                  bus2.reg_write_en, bus2.wb_sel_mem, bus2.pc_en,
                  bus2.illegal_op, bus2.busy};

  function automatic logic [11:0] mk(input logic ready, input logic [2:0] alu,
                                     input logic imm, input logic rd, input logic wr,
                                     input logic regw, input logic wbsel, input logic pc,
                                     input logic ill, input logic busy);
    return {ready, alu, imm, rd, wr, regw, wbsel, pc, ill, busy};
  endfunction

  function automatic bit isLegal(input logic [6:0] op);
    return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One clock: check both instances at the falling edge, then advance past the rising edge.
  task automatic stepCycle(input string tag, input logic [11:0] expVec);
    @(negedge clk);
    checkOutput({tag, ".vec16"}, {20'd0, vec16}, {20'd0, expVec});
    checkOutput({tag, ".vec2"},  {20'd0, vec2},  {20'd0, expVec});
    checkOutput({tag, ".ret16"}, {16'd0, bus16.retired}, retiredCount & 32'hFFFF);
    checkOutput({tag, ".ret2"},  {30'd0, bus2.retired},  retiredCount & 32'h3);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle(input string tag);
    instr_valid = 1'b0;
    opcode      = 7'($urandom);
    mem_ready   = 1'($urandom);
    stepCycle(tag, mk(1, ALU_NOP, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // Present one instruction and follow it to retirement (or skip, if illegal).
  task automatic applyStimulus(input string name, input logic [6:0] op,
                               input int memWait, input bit holdValid);
    bit imm;
    bit done;
    bit isLw;
    bit isSw;
    imm  = (op != OP_ADD);
    isLw = (op == OP_LW);
    isSw = (op == OP_SW);

    instr_valid = 1'b1;
    opcode      = op;
    mem_ready   = 1'($urandom);
    stepCycle({name, ".fetch"}, mk(1, ALU_NOP, 0, 0, 0, 0, 0, 0, 0, 0));

    if (holdValid) begin
      instr_valid = 1'b1;
      opcode      = OP_ADDI;
    end else begin
      instr_valid = 1'($urandom);
      opcode      = 7'($urandom);
    end
    mem_ready = 1'($urandom);

    if (!isLegal(op)) begin
      stepCycle({name, ".decode_ill"}, mk(0, ALU_NOP, 0, 0, 0, 0, 0, 1, 1, 1));
      return;
    end
    stepCycle({name, ".decode"}, mk(0, ALU_NOP, 0, 0, 0, 0, 0, 0, 0, 1));
    mem_ready = 1'($urandom);
    stepCycle({name, ".exec"}, mk(0, ALU_ADD, imm, 0, 0, 0, 0, 0, 0, 1));

    if (isLw || isSw) begin
      for (int w = 0; w <= memWait; w++) begin
        done      = (w == memWait);
        mem_ready = done;
        stepCycle($sformatf("%s.mem%0d", name, w),
                  mk(0, ALU_ADD, 1, isLw, isSw, 0, 0, isSw && done, 0, 1));
      end
      if (isSw) begin
        retiredCount++;
        return;
      end
    end

    mem_ready = 1'($urandom);
    stepCycle({name, ".wb"}, mk(0, ALU_ADD, imm, 0, 0, 1, isLw, 1, 0, 1));
    retiredCount++;
  endtask

  task automatic applyReset(input int cycles);
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
    retiredCount = 0;
    rst_n = 1'b1;
  endtask

  logic [6:0] randOp;
  logic [6:0] legalOps [4];

  initial begin
    compareCount = 0;
    failCount    = 0;
    retiredCount = 0;
    rst_n        = 1'b0;
    instr_valid  = 1'b0;
    opcode       = '0;
    mem_ready    = 1'b0;
    legalOps[0]  = OP_ADD;
    legalOps[1]  = OP_ADDI;
    legalOps[2]  = OP_LW;
    legalOps[3]  = OP_SW;

    applyReset(3);
    idleCycle("post_reset");

    applyStimulus("add",    OP_ADD,      0, 0);
    applyStimulus("sw_w3",  OP_SW,       3, 0);
    applyStimulus("lw",     OP_LW,       0, 0);
    applyStimulus("illegal", 7'b1111111, 0, 0);
    idleCycle("after_illegal");
    applyStimulus("addi",   OP_ADDI,     0, 0);
    applyStimulus("lw_w2",  OP_LW,       2, 0);

    // Reset while a load is waiting in MEM: the load must vanish without a write or PC step.
    instr_valid = 1'b1;
    opcode      = OP_LW;
    mem_ready   = 1'b0;
    stepCycle("rst_lw.fetch", mk(1, ALU_NOP, 0, 0, 0, 0, 0, 0, 0, 0));
    stepCycle("rst_lw.decode", mk(0, ALU_NOP, 0, 0, 0, 0, 0, 0, 0, 1));
    stepCycle("rst_lw.exec", mk(0, ALU_ADD, 1, 0, 0, 0, 0, 0, 0, 1));
    stepCycle("rst_lw.mem", mk(0, ALU_ADD, 1, 1, 0, 0, 0, 0, 0, 1));
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    retiredCount = 0;
    stepCycle("rst_lw.hold", mk(1, ALU_NOP, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    idleCycle("rst_lw.after");

    for (int i = 0; i < 5; i++) begin
      applyStimulus($sformatf("wrap%0d", i), OP_ADDI, 0, 1);
    end
    idleCycle("wrap_done");

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        do randOp = 7'($urandom); while (isLegal(randOp));
      end else begin
        randOp = legalOps[$urandom_range(0, 3)];
      end
      applyStimulus($sformatf("rnd%0d", i), randOp, $urandom_range(0, 3), 0);
      if ($urandom_range(0, 3) == 0) begin
        idleCycle($sformatf("rnd%0d.idle", i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
